// File: rtl/spi_master_arb.sv
// Round-robin arbiter/sequencer sharing one spi_master between NUM_REQ requesters.
// Optional busy-timeout in WAIT_HI enabled by defining SPI_MASTER_ARB_TIMEOUT_EN.
module spi_master_arb #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_OF_CS = 1
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [16*NUM_REQ-1:0]        req_dat_h_i,
    input  logic [16*NUM_REQ-1:0]        req_dat_l_i,
    input  logic [NUM_REQ-1:0]           req_rw_i,
    input  logic [NUM_OF_CS*NUM_REQ-1:0] req_cs_i,
    input  logic [5*NUM_REQ-1:0]         req_h_lng_i,
    input  logic [5*NUM_REQ-1:0]         req_l_lng_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           done_o,
    output logic [15:0]                  rd_dat_o,
    output logic                         err_o,
    output logic                         spi_start_o,
    output logic [15:0]                  dat_wr_h_o,
    output logic [15:0]                  dat_wr_l_o,
    output logic                         cfg_rw_o,
    output logic [NUM_OF_CS-1:0]         cfg_cs_act_o,
    output logic [4:0]                   cfg_h_lng_o,
    output logic [4:0]                   cfg_l_lng_o,
    input  logic                         spi_busy_i,
    input  logic [15:0]                  dat_rd_l_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_idx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [15:0]          r_rd_dat;
    logic                 r_start;
    logic [15:0]          r_dat_h;
    logic [15:0]          r_dat_l;
    logic                 r_rw;
    logic [NUM_OF_CS-1:0] r_cs;
    logic [4:0]           r_h_lng;
    logic [4:0]           r_l_lng;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
    logic [3:0]           r_cnt;
    logic                 r_err;
`endif

    logic                 w_found;
    logic [PTR_W-1:0]     w_sel;
    logic [NUM_REQ-1:0]   w_sel_oh;
    logic [15:0]          w_dat_h;
    logic [15:0]          w_dat_l;
    logic                 w_rw;
    logic [NUM_OF_CS-1:0] w_cs;
    logic [4:0]           w_h_lng;
    logic [4:0]           w_l_lng;
    logic [PTR_W-1:0]     w_ptr_next;

    // Two passes: first set bit at/after the pointer, else the lowest set bit (wrap).
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_oh = '0;
        w_dat_h  = '0;
        w_dat_l  = '0;
        w_rw     = 1'b0;
        w_cs     = '0;
        w_h_lng  = '0;
        w_l_lng  = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!w_found && req_i[k] && ((p == 1) || (PTR_W'(k) >= r_ptr))) begin
                    w_found     = 1'b1;
                    w_sel       = PTR_W'(k);
                    w_sel_oh[k] = 1'b1;
                    w_dat_h     = req_dat_h_i[k*16 +: 16];
                    w_dat_l     = req_dat_l_i[k*16 +: 16];
                    w_rw        = req_rw_i[k];
                    w_cs        = req_cs_i[k*NUM_OF_CS +: NUM_OF_CS];
                    w_h_lng     = req_h_lng_i[k*5 +: 5];
                    w_l_lng     = req_l_lng_i[k*5 +: 5];
                end
            end
        end
    end

    assign w_ptr_next = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + PTR_W'(1);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_rd_dat <= '0;
            r_start  <= 1'b0;
            r_dat_h  <= '0;
            r_dat_l  <= '0;
            r_rw     <= 1'b0;
            r_cs     <= '0;
            r_h_lng  <= '0;
            r_l_lng  <= '0;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= '0;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_sel_oh;
                        r_idx   <= w_sel;
                        r_dat_h <= w_dat_h;
                        r_dat_l <= w_dat_l;
                        r_rw    <= w_rw;
                        r_cs    <= w_cs;
                        r_h_lng <= w_h_lng;
                        r_l_lng <= w_l_lng;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!spi_busy_i) begin
                        r_start <= 1'b1;
                        r_state <= S_WAIT_HI;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_WAIT_HI: begin
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
                    // Eighth WAIT_HI cycle without busy ends the transaction with an error.
                    if (spi_busy_i) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_cnt == 4'd7) begin
                        r_done   <= r_gnt;
                        r_gnt    <= '0;
                        r_err    <= 1'b1;
                        r_rd_dat <= '0;
                        r_ptr    <= w_ptr_next;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
`else
                    if (spi_busy_i) begin
                        r_state <= S_WAIT_LO;
                    end
`endif
                end
                S_WAIT_LO: begin
                    if (!spi_busy_i) begin
                        r_rd_dat <= dat_rd_l_i;
                        r_done   <= r_gnt;
                        r_gnt    <= '0;
                        r_ptr    <= w_ptr_next;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign done_o       = r_done;
    assign rd_dat_o     = r_rd_dat;
    assign spi_start_o  = r_start;
    assign dat_wr_h_o   = r_dat_h;
    assign dat_wr_l_o   = r_dat_l;
    assign cfg_rw_o     = r_rw;
    assign cfg_cs_act_o = r_cs;
    assign cfg_h_lng_o  = r_h_lng;
    assign cfg_l_lng_o  = r_l_lng;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
    assign err_o        = r_err;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb with a small behavioural spi_master busy model.
// Timeout cases follow SPI_MASTER_ARB_TIMEOUT_EN as seen by this compile.
module tb_spi_master_arb;

    localparam int NR  = 4;
    localparam int NCS = 1;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NR-1:0]     req_i = '0;
    logic [16*NR-1:0]  req_dat_h_i;
    logic [16*NR-1:0]  req_dat_l_i;
    logic [NR-1:0]     req_rw_i;
    logic [NCS*NR-1:0] req_cs_i;
    logic [5*NR-1:0]   req_h_lng_i;
    logic [5*NR-1:0]   req_l_lng_i;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     done_o;
    logic [15:0]       rd_dat_o;
    logic              err_o;
    logic              spi_start_o;
    logic [15:0]       dat_wr_h_o;
    logic [15:0]       dat_wr_l_o;
    logic              cfg_rw_o;
    logic [NCS-1:0]    cfg_cs_act_o;
    logic [4:0]        cfg_h_lng_o;
    logic [4:0]        cfg_l_lng_o;
    logic              spi_busy_i = 1'b0;
    logic [15:0]       dat_rd_l_i = '0;

    logic [15:0] th  [NR];
    logic [15:0] tl  [NR];
    logic        trw [NR];
    logic [4:0]  thl [NR];
    logic [4:0]  tll [NR];

    always #5 aclk = ~aclk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_dat_h_i[i*16 +: 16] = th[i];
            req_dat_l_i[i*16 +: 16] = tl[i];
            req_rw_i[i]             = trw[i];
            req_cs_i[i]             = 1'b1;
            req_h_lng_i[i*5 +: 5]   = thl[i];
            req_l_lng_i[i*5 +: 5]   = tll[i];
        end
    end

    spi_master_arb #(.NUM_REQ(NR), .NUM_OF_CS(NCS)) dut (
        .aclk(aclk), .aresetn(aresetn), .req_i(req_i),
        .req_dat_h_i(req_dat_h_i), .req_dat_l_i(req_dat_l_i), .req_rw_i(req_rw_i),
        .req_cs_i(req_cs_i), .req_h_lng_i(req_h_lng_i), .req_l_lng_i(req_l_lng_i),
        .gnt_o(gnt_o), .done_o(done_o), .rd_dat_o(rd_dat_o), .err_o(err_o),
        .spi_start_o(spi_start_o), .dat_wr_h_o(dat_wr_h_o), .dat_wr_l_o(dat_wr_l_o),
        .cfg_rw_o(cfg_rw_o), .cfg_cs_act_o(cfg_cs_act_o), .cfg_h_lng_o(cfg_h_lng_o),
        .cfg_l_lng_o(cfg_l_lng_o), .spi_busy_i(spi_busy_i), .dat_rd_l_i(dat_rd_l_i)
    );

    // spi_master stand-in: busy rises the cycle after start, stays high m_len cycles.
    int          m_len   = 4;
    logic        m_stuck = 1'b0;
    logic [15:0] m_rd    = '0;
    int          m_cnt   = 0;
    int          m_viol  = 0;

    always @(posedge aclk) begin
        if (!aresetn) begin
            spi_busy_i <= 1'b0;
            m_cnt      <= 0;
        end else begin
            if (spi_start_o && spi_busy_i) m_viol <= m_viol + 1;
            if (spi_start_o && !spi_busy_i && !m_stuck) begin
                spi_busy_i <= 1'b1;
                m_cnt      <= m_len;
            end else if (spi_busy_i) begin
                if (m_cnt == 1) begin
                    spi_busy_i <= 1'b0;
                    dat_rd_l_i <= m_rd;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        for (int n = 0; n < 40 && !spi_start_o; n++) @(negedge aclk);
        check(tag, 32'(spi_start_o), 32'd1);
    endtask

    task automatic wait_done(input string tag, output logic [NR-1:0] d, output int lat);
        lat = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge aclk);
            lat++;
            if (done_o != '0) break;
        end
        d = done_o;
        check({tag, "_seen"}, 32'(d != '0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [NR-1:0] d;
    logic [NR-1:0] e;
    int            lat;

    initial begin
        for (int i = 0; i < NR; i++) begin
            th[i]  = 16'h1100 + 16'(i);
            tl[i]  = 16'h2200 + 16'(i);
            trw[i] = 1'b0;
            thl[i] = 5'd4;
            tll[i] = 5'd4;
        end
        repeat (3) @(negedge aclk);
        check("rst_gnt",   32'(gnt_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_start", 32'(spi_start_o), 32'd0);
        check("rst_rd",    32'(rd_dat_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        check("rst_dath",  32'(dat_wr_h_o), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Round robin from pointer 0 with all requests held
        m_rd  = 16'h0C00;
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done("rr", d, lat);
            e = 4'b0001 << (i % 4);
            check("rr_order", 32'(d), 32'(e));
            check("rr_rd", 32'(rd_dat_o), 32'h0C00);
            @(negedge aclk);
            check("rr_done_1cyc", 32'(done_o), 32'd0);
            if (i == 4) req_i = '0;
        end
        repeat (2) @(negedge aclk);

        // Single write from requester 2 (pointer now 1)
        th[2] = 16'hA5A5; tl[2] = 16'h1234; thl[2] = 5'd8; tll[2] = 5'd16; trw[2] = 1'b0;
        m_rd  = 16'h3333;
        req_i = 4'b0100;
        @(negedge aclk);
        check("wr_gnt",   32'(gnt_o), 32'h4);
        check("wr_dath",  32'(dat_wr_h_o), 32'hA5A5);
        check("wr_datl",  32'(dat_wr_l_o), 32'h1234);
        check("wr_hlng",  32'(cfg_h_lng_o), 32'd8);
        check("wr_llng",  32'(cfg_l_lng_o), 32'd16);
        check("wr_rw",    32'(cfg_rw_o), 32'd0);
        check("wr_cs",    32'(cfg_cs_act_o), 32'd1);
        check("wr_nostart", 32'(spi_start_o), 32'd0);
        @(negedge aclk);
        check("wr_start", 32'(spi_start_o), 32'd1);
        wait_done("wr", d, lat);
        check("wr_done",  32'(d), 32'h4);
        check("wr_lat",   32'(lat), 32'd6);
        check("wr_gnt_clr", 32'(gnt_o), 32'd0);
        check("wr_err",   32'(err_o), 32'd0);
        check("wr_dath_hold", 32'(dat_wr_h_o), 32'hA5A5);
        req_i = '0;
        @(negedge aclk);
        check("wr_done_1cyc", 32'(done_o), 32'd0);
        repeat (2) @(negedge aclk);

        // Read return from requester 1
        trw[1] = 1'b1;
        m_rd   = 16'hBEEF;
        req_i  = 4'b0010;
        wait_done("rd", d, lat);
        check("rd_done", 32'(d), 32'h2);
        check("rd_data", 32'(rd_dat_o), 32'hBEEF);
        check("rd_rw",   32'(cfg_rw_o), 32'd1);
        req_i = '0;
        repeat (3) @(negedge aclk);

        // Serve 3, then 0101 must give 0 before 2
        m_rd  = 16'h5555;
        req_i = 4'b1000;
        wait_done("sk3", d, lat);
        check("sk_3", 32'(d), 32'h8);
        req_i = 4'b0101;
        wait_done("sk0", d, lat);
        check("sk_0", 32'(d), 32'h1);
        req_i = 4'b0100;
        wait_done("sk2", d, lat);
        check("sk_2", 32'(d), 32'h4);
        req_i = '0;
        repeat (3) @(negedge aclk);

        // Reset while in WAIT_LO
        m_len = 10;
        req_i = 4'b0001;
        for (int n = 0; n < 40 && !spi_busy_i; n++) @(negedge aclk);
        check("rs_busy", 32'(spi_busy_i), 32'd1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        check("rs_gnt",   32'(gnt_o), 32'd0);
        check("rs_done",  32'(done_o), 32'd0);
        check("rs_rd",    32'(rd_dat_o), 32'd0);
        check("rs_datl",  32'(dat_wr_l_o), 32'd0);
        aresetn = 1'b1;
        m_len   = 4;
        m_rd    = 16'h7777;
        wait_done("rs_next", d, lat);
        check("rs_next_done", 32'(d), 32'h1);
        check("rs_next_rd",   32'(rd_dat_o), 32'h7777);
        req_i = '0;
        repeat (3) @(negedge aclk);

        // Busy never rises
        m_stuck = 1'b1;
        req_i   = 4'b0100;
        wait_start("to_start");
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
        wait_done("to", d, lat);
        check("to_done", 32'(d), 32'h4);
        check("to_err",  32'(err_o), 32'd1);
        check("to_rd",   32'(rd_dat_o), 32'd0);
        check("to_lat",  32'(lat >= 8 && lat <= 9), 32'd1);
        req_i = '0;
        @(negedge aclk);
        check("to_err_1cyc", 32'(err_o), 32'd0);
`else
        repeat (20) @(negedge aclk);
        check("hang_gnt",  32'(gnt_o), 32'h4);
        check("hang_done", 32'(done_o), 32'd0);
        check("hang_err",  32'(err_o), 32'd0);
        req_i = '0;
`endif
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b0;
        m_stuck = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        check("no_start_while_busy", 32'(m_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
